// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks every in-flight register write from the EX stage through DEPTH
//   post-EX stages (E[0] youngest) and the writeback register W (oldest
//   forwarding source). Forwards the youngest ready value to rs1/rs2, raises
//   a load-use stall when the youngest match is still waiting for memory,
//   drives the register-file write port and counts stall cycles.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   iss_*               instruction leaving EX (valid, writes rd, is load, rd, ALU data)
//   rs1/rs2, rsN_used   EX source registers and whether they are really read
//   ld_data             memory read data for the load currently in E[LOAD_STAGE]
//   stall_cnt_clr       synchronous clear of the stall counter
//   rsN_fwd_en/val      forwarding select and value per source
//   stall               hold IF/EX and insert a bubble
//   wb_en/wb_rd/wb_data register-file write port
//   stall_cnt           saturating count of stall cycles
module hazard_scoreboard #(
   parameter int XLEN       = 32,
   parameter int RBITS      = 5,
   parameter int DEPTH      = 2,
   parameter int LOAD_STAGE = 0,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             iss_valid,
   input  logic             iss_wb_en,
   input  logic             iss_is_load,
   input  logic [RBITS-1:0] iss_rd,
   input  logic [XLEN-1:0]  iss_data,
   input  logic [RBITS-1:0] rs1,
   input  logic [RBITS-1:0] rs2,
   input  logic             rs1_used,
   input  logic             rs2_used,
   input  logic [XLEN-1:0]  ld_data,
   input  logic             stall_cnt_clr,
   output logic             rs1_fwd_en,
   output logic             rs2_fwd_en,
   output logic [XLEN-1:0]  rs1_fwd_val,
   output logic [XLEN-1:0]  rs2_fwd_val,
   output logic             stall,
   output logic             wb_en,
   output logic [RBITS-1:0] wb_rd,
   output logic [XLEN-1:0]  wb_data,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic            hit;
      logic            ready;
      logic [XLEN-1:0] data;
   } fwd_t;

   logic [DEPTH-1:0] e_valid_q, e_valid_d;
   logic [DEPTH-1:0] e_ready_q, e_ready_d;
   logic [RBITS-1:0] e_rd_q   [DEPTH];
   logic [RBITS-1:0] e_rd_d   [DEPTH];
   logic [XLEN-1:0]  e_data_q [DEPTH];
   logic [XLEN-1:0]  e_data_d [DEPTH];

   logic             wb_en_q, wb_en_d;
   logic [RBITS-1:0] wb_rd_q, wb_rd_d;
   logic [XLEN-1:0]  wb_data_q, wb_data_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Each entry as it looks when it leaves its stage: the LOAD_STAGE entry
   // picks up ld_data on its way out if it is a pending load.
   logic [DEPTH-1:0] x_ready;
   logic [XLEN-1:0]  x_data [DEPTH];

   fwd_t f1, f2;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         x_ready[i] = e_ready_q[i];
         x_data[i]  = e_data_q[i];
         if (i == LOAD_STAGE && e_valid_q[i] && !e_ready_q[i]) begin
            x_ready[i] = 1'b1;
            x_data[i]  = ld_data;
         end
      end
   end

   // Forwarding lookup: start from W and walk toward E[0] so that a younger
   // match always overwrites an older one, ready or not.
   always_comb begin
      // NOTE: every variable gets a default at the top of an always_comb;
      // a path that leaves one unassigned would infer a latch.
      f1 = '0;
      f2 = '0;
      if (wb_en_q && wb_rd_q == rs1) begin
         f1.hit   = 1'b1;
         f1.ready = 1'b1;
         f1.data  = wb_data_q;
      end
      if (wb_en_q && wb_rd_q == rs2) begin
         f2.hit   = 1'b1;
         f2.ready = 1'b1;
         f2.data  = wb_data_q;
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (e_valid_q[i] && e_rd_q[i] == rs1) begin
            f1.hit   = 1'b1;
            f1.ready = e_ready_q[i];
            f1.data  = e_data_q[i];
         end
         if (e_valid_q[i] && e_rd_q[i] == rs2) begin
            f2.hit   = 1'b1;
            f2.ready = e_ready_q[i];
            f2.data  = e_data_q[i];
         end
      end
      // x0 is never forwarded, and an unread source never matches.
      if (!rs1_used || rs1 == '0) f1 = '0;
      if (!rs2_used || rs2 == '0) f2 = '0;
   end

   assign rs1_fwd_en  = f1.hit & f1.ready;
   assign rs2_fwd_en  = f2.hit & f2.ready;
   assign rs1_fwd_val = rs1_fwd_en ? f1.data : '0;
   assign rs2_fwd_val = rs2_fwd_en ? f2.data : '0;
   assign stall       = (f1.hit & ~f1.ready) | (f2.hit & ~f2.ready);

   // Unconditional shift; a stalled issue enters E[0] as a bubble.
   always_comb begin
      e_valid_d[0] = iss_valid & iss_wb_en & ~stall & (iss_rd != '0);
      e_rd_d[0]    = iss_rd;
      e_ready_d[0] = ~iss_is_load;
      e_data_d[0]  = iss_data;
      for (int i = 1; i < DEPTH; i++) begin
         e_valid_d[i] = e_valid_q[i-1];
         e_rd_d[i]    = e_rd_q[i-1];
         e_ready_d[i] = x_ready[i-1];
         e_data_d[i]  = x_data[i-1];
      end
      wb_en_d   = e_valid_q[DEPTH-1] & x_ready[DEPTH-1];
      wb_rd_d   = e_rd_q[DEPTH-1];
      wb_data_d = x_data[DEPTH-1];

      stall_cnt_d = stall_cnt_q;
      if (stall_cnt_clr) begin
         stall_cnt_d = '0;
      end else if (stall && stall_cnt_q != '1) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // NOTE: sequential state is updated only with non-blocking assignments so
   // every flop samples its _d value from before the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_valid_q   <= '0;
         e_ready_q   <= '0;
         // NOTE: the entry array is a handful of flops, so rd/data are reset
         // along with the flags; nothing downstream ever sees stale X values.
         for (int i = 0; i < DEPTH; i++) begin
            e_rd_q[i]   <= '0;
            e_data_q[i] <= '0;
         end
         wb_en_q     <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         e_valid_q   <= e_valid_d;
         e_ready_q   <= e_ready_d;
         for (int i = 0; i < DEPTH; i++) begin
            e_rd_q[i]   <= e_rd_d[i];
            e_data_q[i] <= e_data_d[i];
         end
         wb_en_q     <= wb_en_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign wb_en     = wb_en_q;
   assign wb_rd     = wb_rd_q;
   assign wb_data   = wb_data_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Directed scenarios with literal expectations, then randomized traffic,
//   all compared every cycle against a queue-based model of the scoreboard.
module tb_hazard_scoreboard;

   localparam int XLEN       = 32;
   localparam int RBITS      = 5;
   localparam int DEPTH      = 2;
   localparam int LOAD_STAGE = 0;
   localparam int CNT_W      = 2;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             iss_valid, iss_wb_en, iss_is_load;
   logic [RBITS-1:0] iss_rd;
   logic [XLEN-1:0]  iss_data;
   logic [RBITS-1:0] rs1, rs2;
   logic             rs1_used, rs2_used;
   logic [XLEN-1:0]  ld_data;
   logic             stall_cnt_clr;
   logic             rs1_fwd_en, rs2_fwd_en;
   logic [XLEN-1:0]  rs1_fwd_val, rs2_fwd_val;
   logic             stall;
   logic             wb_en;
   logic [RBITS-1:0] wb_rd;
   logic [XLEN-1:0]  wb_data;
   logic [CNT_W-1:0] stall_cnt;

   hazard_scoreboard #(
      .XLEN(XLEN), .RBITS(RBITS), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_wb_en(iss_wb_en), .iss_is_load(iss_is_load),
      .iss_rd(iss_rd), .iss_data(iss_data),
      .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
      .ld_data(ld_data), .stall_cnt_clr(stall_cnt_clr),
      .rs1_fwd_en(rs1_fwd_en), .rs2_fwd_en(rs2_fwd_en),
      .rs1_fwd_val(rs1_fwd_val), .rs2_fwd_val(rs2_fwd_val),
      .stall(stall), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit               valid;
      logic [RBITS-1:0] rd;
      bit               ready;
      logic [XLEN-1:0]  data;
   } ent_t;

   ent_t             pipe[$];   // index 0 = youngest in-flight write
   bit               m_wb_en;
   logic [RBITS-1:0] m_wb_rd;
   logic [XLEN-1:0]  m_wb_data;
   int               m_cnt;

   // inputs and expected stall captured mid-cycle, consumed at the next edge
   bit               s_valid, s_wb_en, s_is_load, s_clr, s_stall;
   logic [RBITS-1:0] s_rd;
   logic [XLEN-1:0]  s_data, s_ld;

   bit               m_e1, m_e2, m_n1, m_n2;
   logic [XLEN-1:0]  m_v1, m_v2;

   task automatic model_reset();
      ent_t z;
      z.valid = 0; z.rd = '0; z.ready = 0; z.data = '0;
      pipe.delete();
      for (int i = 0; i < DEPTH; i++) pipe.push_back(z);
      m_wb_en = 0; m_wb_rd = '0; m_wb_data = '0; m_cnt = 0;
   endtask

   // Youngest matching writer decides: ready -> forward, pending -> stall.
   function automatic void model_fwd(input logic [RBITS-1:0] rs, input bit used,
                                     output bit en, output logic [XLEN-1:0] val,
                                     output bit pend);
      bit found;
      en = 0; val = '0; pend = 0; found = 0;
      if (used && rs != 0) begin
         for (int i = 0; i < pipe.size(); i++) begin
            if (!found && pipe[i].valid && pipe[i].rd == rs) begin
               found = 1;
               if (pipe[i].ready) begin en = 1; val = pipe[i].data; end
               else pend = 1;
            end
         end
         if (!found && m_wb_en && m_wb_rd == rs) begin
            en = 1; val = m_wb_data;
         end
      end
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         model_reset();
      end else begin
         ent_t n, o, t;
         n.valid = s_valid && s_wb_en && !s_stall && s_rd != 0;
         n.rd    = s_rd;
         n.ready = !s_is_load;
         n.data  = s_data;
         pipe.push_front(n);
         // the entry that just left E[LOAD_STAGE] now sits one slot further on
         t = pipe[LOAD_STAGE+1];
         if (t.valid && !t.ready) begin
            t.ready = 1; t.data = s_ld;
            pipe[LOAD_STAGE+1] = t;
         end
         o = pipe.pop_back();
         m_wb_en   = o.valid && o.ready;
         m_wb_rd   = o.rd;
         m_wb_data = o.data;
         if (s_clr) m_cnt = 0;
         else if (s_stall && m_cnt < CNT_MAX) m_cnt++;
      end
   end

   always @(negedge clk) begin
      model_fwd(rs1, rs1_used, m_e1, m_v1, m_n1);
      model_fwd(rs2, rs2_used, m_e2, m_v2, m_n2);
      s_stall   = m_n1 | m_n2;
      s_valid   = iss_valid;   s_wb_en = iss_wb_en; s_is_load = iss_is_load;
      s_rd      = iss_rd;      s_data  = iss_data;  s_ld      = ld_data;
      s_clr     = stall_cnt_clr;
      if (rst) begin
         check("m_rs1_fwd_en", rs1_fwd_en, m_e1);
         check("m_rs2_fwd_en", rs2_fwd_en, m_e2);
         if (!m_n1) check("m_rs1_fwd_val", rs1_fwd_val, m_v1);
         if (!m_n2) check("m_rs2_fwd_val", rs2_fwd_val, m_v2);
         check("m_stall", stall, s_stall);
         check("m_wb_en", wb_en, m_wb_en);
         if (m_wb_en) begin
            check("m_wb_rd", wb_rd, m_wb_rd);
            check("m_wb_data", wb_data, m_wb_data);
         end
         check("m_stall_cnt", stall_cnt, m_cnt);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_iss(input bit v, input bit w, input bit l, input int rd, input logic [XLEN-1:0] d);
      iss_valid = v; iss_wb_en = w; iss_is_load = l;
      iss_rd = RBITS'(rd); iss_data = d;
   endtask

   task automatic set_rs(input int r1, input bit u1, input int r2, input bit u2);
      rs1 = RBITS'(r1); rs1_used = u1; rs2 = RBITS'(r2); rs2_used = u2;
   endtask

   task automatic idle();
      set_iss(0, 0, 0, 0, '0);
      set_rs(0, 0, 0, 0);
      stall_cnt_clr = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   initial begin
      model_reset();
      idle();
      ld_data = '0;

      // reset state: no forwarding even for a used source, port cleared
      #1 set_rs(5, 1, 5, 1);
      #1;
      check("rst_fwd_en1", rs1_fwd_en, 0);
      check("rst_stall", stall, 0);
      check("rst_wb_en", wb_en, 0);
      check("rst_wb_rd", wb_rd, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_stall_cnt", stall_cnt, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;

      // ALU result forwarded from E[0], then E[1], then written back
      set_iss(1, 1, 0, 5, 32'h11); set_rs(0, 0, 0, 0);
      step(); idle(); set_rs(5, 1, 0, 0);
      at_neg();
      check("s1_e0_fwd_en", rs1_fwd_en, 1);
      check("s1_e0_fwd_val", rs1_fwd_val, 32'h11);
      check("s1_e0_stall", stall, 0);
      step(); at_neg();
      check("s1_e1_fwd_val", rs1_fwd_val, 32'h11);
      step(); set_rs(0, 0, 0, 0); at_neg();
      check("s1_wb_en", wb_en, 1);
      check("s1_wb_rd", wb_rd, 5);
      check("s1_wb_data", wb_data, 32'h11);

      // load-use at distance 1: exactly one stall cycle
      step(); set_iss(1, 1, 1, 7, 32'hBAD);
      step(); idle(); set_rs(0, 0, 7, 1); ld_data = 32'hDEAD_BEEF;
      at_neg();
      check("s2_stall", stall, 1);
      check("s2_fwd_en_pend", rs2_fwd_en, 0);
      step(); at_neg();
      check("s2_stall_done", stall, 0);
      check("s2_fwd_val", rs2_fwd_val, 32'hDEAD_BEEF);
      check("s2_stall_cnt", stall_cnt, 1);

      // youngest writer wins; a younger ALU write hides an older load
      step(); idle(); ld_data = 32'h1234; set_iss(1, 1, 0, 3, 32'hA);
      step(); set_iss(1, 1, 0, 3, 32'hB);
      step(); idle(); set_rs(3, 1, 0, 0); at_neg();
      check("s3_youngest", rs1_fwd_val, 32'hB);
      step(); idle(); set_iss(1, 1, 1, 3, 32'h0);
      step(); set_iss(1, 1, 0, 3, 32'hC);
      step(); idle(); set_rs(3, 1, 3, 1); at_neg();
      check("s3_no_stall", stall, 0);
      check("s3_rs1_c", rs1_fwd_val, 32'hC);
      check("s3_rs2_c", rs2_fwd_val, 32'hC);

      // x0 and unused sources never forward; rd=0 never written back
      step(); idle(); set_iss(1, 1, 0, 0, 32'h55);
      step(); set_iss(1, 1, 0, 9, 32'h99); set_rs(0, 1, 0, 1); at_neg();
      check("s4_x0_fwd_en", rs1_fwd_en, 0);
      check("s4_x0_stall", stall, 0);
      step(); idle(); set_rs(9, 0, 0, 0); at_neg();
      check("s4_unused_fwd_en", rs1_fwd_en, 0);
      step(); idle(); at_neg();
      check("s4_rd0_no_wb", wb_en, 0);

      // counter saturation under repeated load-use, then clear during a stall
      step(); idle(); stall_cnt_clr = 1;
      repeat (3) step();
      stall_cnt_clr = 0;
      set_iss(1, 1, 1, 4, 32'h0); set_rs(4, 1, 0, 0);
      repeat (9) step();
      stall_cnt_clr = 1;
      at_neg();
      check("s5_stall", stall, 1);
      check("s5_saturated", stall_cnt, 3);
      step(); stall_cnt_clr = 0; at_neg();
      check("s5_cleared", stall_cnt, 0);

      // asynchronous reset in the middle of a stall
      step(); idle(); set_iss(1, 1, 0, 8, 32'h88);
      step(); set_iss(1, 1, 0, 6, 32'h66);
      step(); set_iss(1, 1, 1, 7, 32'h0);
      step(); idle(); set_rs(6, 1, 7, 1);
      at_neg();
      check("s6_pre_stall", stall, 1);
      check("s6_pre_fwd_en1", rs1_fwd_en, 1);
      check("s6_pre_wb_en", wb_en, 1);
      #2 rst = 1'b0;
      #1;
      check("s6_rst_stall", stall, 0);
      check("s6_rst_wb_en", wb_en, 0);
      check("s6_rst_fwd_en1", rs1_fwd_en, 0);
      check("s6_rst_fwd_en2", rs2_fwd_en, 0);
      idle();
      @(posedge clk);
      #2 rst = 1'b1;
      set_iss(1, 1, 0, 5, 32'h11);
      step(); idle(); set_rs(5, 1, 0, 0); at_neg();
      check("s6_after_fwd_en", rs1_fwd_en, 1);
      check("s6_after_fwd_val", rs1_fwd_val, 32'h11);

      // randomized traffic on a small register window to force collisions
      for (int n = 0; n < 1500; n++) begin
         step();
         iss_valid     = ($urandom_range(0, 3) != 0);
         iss_wb_en     = ($urandom_range(0, 4) != 0);
         iss_is_load   = ($urandom_range(0, 2) == 0);
         iss_rd        = RBITS'($urandom_range(0, 7));
         iss_data      = $urandom;
         rs1           = RBITS'($urandom_range(0, 7));
         rs2           = RBITS'($urandom_range(0, 7));
         rs1_used      = ($urandom_range(0, 3) != 0);
         rs2_used      = ($urandom_range(0, 3) != 0);
         ld_data       = $urandom;
         stall_cnt_clr = ($urandom_range(0, 19) == 0);
      end
      step(); idle();
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
